// File: rtl/dmem_ws.sv
// Data memory with RV32I byte/halfword/word access, valid/ready request handshake,
// a configurable number of wait states and a one-cycle response pulse.
// Only WIDTH=32 is supported (four byte lanes).
module dmem_ws #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             we,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rdata,
  output logic             err
);

  localparam int unsigned LANES = WIDTH / 8;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned BAW   = AW + 2;
  localparam int unsigned CW    = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic             we;
    logic [2:0]       funct3;
    logic [BAW-1:0]   addr;
    logic [WIDTH-1:0] wdata;
  } req_t;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  req_t             req_q, req_d;
  logic             ready_q, ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  logic [WIDTH-1:0] mem_q [DEPTH];

  req_t             cur_req;
  logic             legal;
  logic             aligned;
  logic             acc_err;
  logic             enter_resp;
  logic             mem_we;
  logic [AW-1:0]    widx;
  logic [WIDTH-1:0] rd_word;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [WIDTH-1:0] load_val;
  logic [LANES-1:0] be;
  logic [WIDTH-1:0] wlane;
  logic             unused_addr_hi;

  // Upper address bits wrap away; fold them so they are consumed.
  assign unused_addr_hi = ^addr[WIDTH-1:BAW];

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign err       = err_q;
  assign rdata     = rdata_q;

  // Request seen by the datapath: live inputs while idle, latched copy afterwards.
  always_comb begin
    cur_req = req_q;
    if (state_q == S_IDLE) begin
      cur_req.we     = we;
      cur_req.funct3 = funct3;
      cur_req.addr   = addr[BAW-1:0];
      cur_req.wdata  = wdata;
    end
  end

  // Access legality and alignment decode.
  always_comb begin
    legal   = 1'b0;
    aligned = 1'b0;
    case (cur_req.funct3)
      3'b000: begin legal = 1'b1;        aligned = 1'b1;                         end
      3'b001: begin legal = 1'b1;        aligned = ~cur_req.addr[0];             end
      3'b010: begin legal = 1'b1;        aligned = (cur_req.addr[1:0] == 2'b00); end
      3'b100: begin legal = ~cur_req.we; aligned = 1'b1;                         end
      3'b101: begin legal = ~cur_req.we; aligned = ~cur_req.addr[0];             end
      default: begin legal = 1'b0;       aligned = 1'b0;                         end
    endcase
  end

  assign acc_err = ~(legal & aligned);
  assign widx    = cur_req.addr[BAW-1:2];
  assign rd_word = mem_q[widx];

  // Store byte enables and lane-replicated write data.
  always_comb begin
    be    = '0;
    wlane = cur_req.wdata;
    case (cur_req.funct3[1:0])
      2'b00: begin
        be    = LANES'(1) << cur_req.addr[1:0];
        wlane = {4{cur_req.wdata[7:0]}};
      end
      2'b01: begin
        be    = cur_req.addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{cur_req.wdata[15:0]}};
      end
      default: begin
        be    = '1;
        wlane = cur_req.wdata;
      end
    endcase
  end

  // Load lane extraction and sign/zero extension.
  always_comb begin
    rd_byte  = 8'h00;
    rd_half  = cur_req.addr[1] ? rd_word[31:16] : rd_word[15:0];
    load_val = '0;
    case (cur_req.addr[1:0])
      2'b00:   rd_byte = rd_word[7:0];
      2'b01:   rd_byte = rd_word[15:8];
      2'b10:   rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    case (cur_req.funct3)
      3'b000:  load_val = {{(WIDTH-8){rd_byte[7]}}, rd_byte};
      3'b001:  load_val = {{(WIDTH-16){rd_half[15]}}, rd_half};
      3'b010:  load_val = rd_word;
      3'b100:  load_val = {{(WIDTH-8){1'b0}}, rd_byte};
      3'b101:  load_val = {{(WIDTH-16){1'b0}}, rd_half};
      default: load_val = '0;
    endcase
  end

  // FSM next state, wait counter and request latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          req_d   = cur_req;
          cnt_d   = CW'(WAIT_STATES);
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
  // A store never commits while reset is held.
  assign mem_we     = enter_resp && cur_req.we && ~acc_err && rst;

  // Registered outputs: ready follows the next state, response fields load on entry to RESP.
  always_comb begin
    ready_d     = (state_d == S_IDLE);
    rsp_valid_d = 1'b0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    if (enter_resp) begin
      rsp_valid_d = 1'b1;
      err_d       = acc_err;
      rdata_d     = (acc_err || cur_req.we) ? '0 : load_val;
    end
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  // Byte-lane RAM write; contents are not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int l = 0; l < int'(LANES); l++) begin
        if (be[l]) begin
          mem_q[widx][8*l +: 8] <= wlane[8*l +: 8];
        end
      end
    end
  end

endmodule

// File: doc/dmem_ws.md
Name: dmem_ws

Overview:
- Parametrised successor to the single-cycle word-only data memory in the pipelined RISC-V core.
- Adds byte and halfword accesses selected by RV32I funct3, configurable depth, and a configurable number of wait states.
- A valid/ready request interface plus a one-cycle response pulse lets the pipeline stall on slow memory.
- Sits between the core's MEM stage and the data RAM; the core holds its MEM stage while a request is pending.

Parameters:
- WIDTH, 32, data/address width; byte lanes = WIDTH/8; only 32 is supported.
- DEPTH, 64, number of WIDTH-bit words; power of two, minimum 4.
- WAIT_STATES, 1, extra cycles spent in WAIT before the response; legal range 0..7.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- we  in  1  1 = store, 0 = load; sampled on accept.
- funct3  in  3  access type (RV32I load/store encoding); sampled on accept.
- addr  in  WIDTH  byte address; sampled on accept.
- wdata  in  WIDTH  store data, right-aligned; sampled on accept.
- rsp_valid  out  1  one-cycle pulse: access complete.
- rdata  out  WIDTH  formatted load result.
- err  out  1  qualifies rsp_valid: misaligned access or illegal funct3.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, wait counter=0, rsp_valid=0, rdata=0, err=0, req_ready=1 once reset is released.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. If req_valid=1, latch we, funct3, addr, wdata and load counter with WAIT_STATES. Go to WAIT if WAIT_STATES>0, otherwise go to RESP.
  - WAIT: req_ready=0. Decrement the counter each cycle; when it reaches 1, go to RESP on the next edge.
  - RESP: req_ready=0. rsp_valid=1 and err is valid for exactly this cycle. Always go to IDLE next.
- Latency and throughput:
  - Accept edge to rsp_valid high = WAIT_STATES+1 cycles.
  - One request per WAIT_STATES+2 cycles; a new request is never accepted in WAIT or RESP.
- Word index = addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH.
- Access decode (funct3 → access, aligned when):
  - 000 → LB / SB, always aligned.
  - 001 → LH / SH, aligned when addr[0]=0.
  - 010 → LW / SW, aligned when addr[1:0]=0.
  - 100 → LBU, always aligned.
  - 101 → LHU, aligned when addr[0]=0.
  - Any other funct3, and loads-only codes (100, 101) with we=1, are illegal.
- Error handling:
  - A misaligned or illegal request is still accepted and completes with the same latency.
  - In RESP: err=1, no RAM write, rdata=0.
- Store commit:
  - RAM is written on the edge that enters RESP, only when err=0.
  - Only the addressed byte lanes are written: SB writes lane addr[1:0] with wdata[7:0]; SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0]; SW writes all four lanes.
  - Stores drive rdata=0 in RESP.
- Load result:
  - The RAM word is read on the edge that enters RESP and registered into rdata.
  - The selected byte or half is shifted to bit 0 and sign-extended (LB, LH) or zero-extended (LBU, LHU).
  - rdata holds its value after RESP until the next response.
- Inputs are ignored while req_ready=0; changing them mid-request has no effect.
- Reset asserted in WAIT or RESP: the FSM returns to IDLE, any pending store is discarded (not committed), and rsp_valid and err drop immediately.

Test Plan:
- WAIT_STATES=1: SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 → store rsp_valid 2 cycles after accept, err=0; load rdata=0xDEADBEEF 2 cycles after its accept; req_ready low for 2 cycles after each accept.
- Sub-word loads after the word above: LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE; LH 0x10 → 0xFFFFBEEF; LHU 0x12 → 0x0000DEAD.
- Byte-lane store: SB 0x11 wdata=0x000000AA over 0xDEADBEEF, then LW 0x10 → 0xDEADAAEF; SH 0x12 wdata=0x1234 then LW 0x10 → 0x1234AAEF.
- Errors:
  - LW 0x12 → err=1, rdata=0.
  - SH 0x11 wdata=0xFFFF → err=1, then LW 0x10 still returns 0x1234AAEF.
  - funct3=011 → err=1 with normal latency.
- Latency sweep: WAIT_STATES=0 and 7 → rsp_valid 1 and 8 cycles after accept; req_valid held high continuously gives exactly one accept per 2 and 9 cycles respectively.
- Reset mid-operation (WAIT_STATES=3): SW 0x20 wdata=0x55, rst=0 during WAIT → rsp_valid stays 0, req_ready=1 after release; LW 0x20 returns the pre-store value. Also check address wrap: DEPTH=64, SW 0x104 wdata=0x77 then LW 0x004 → 0x77.
